// File: rtl/ahb_uart_fifo_pkg.sv
// ahb_uart_fifo_pkg: register map, CTRL/STAT bit positions, UART FSM states and parity helper
package ahb_uart_fifo_pkg;
  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_CTRL = 2'd1;
  localparam logic [1:0] REG_STAT = 2'd2;
  localparam logic [1:0] REG_BAUD = 2'd3;
  localparam int CTRL_TX_EN   = 0;
  localparam int CTRL_RX_EN   = 1;
  localparam int CTRL_PAR_EN  = 2;
  localparam int CTRL_PAR_ODD = 3;
  localparam int CTRL_RXNE_IE = 4;
  localparam int CTRL_TXE_IE  = 5;
  localparam int STAT_RX_OVR  = 5;
  localparam int STAT_PAR_ERR = 6;
  localparam int STAT_TX_OVF  = 7;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_t;
  function automatic logic parity(input logic [7:0] d, input logic odd);
    return ^d ^ odd;
  endfunction
endpackage

// File: rtl/ahb_uart_fifo_sync.sv
// uart_sync_fifo: single-clock FIFO with first-word-fall-through head output
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rp];
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/ahb_uart_fifo.sv
// ahb_uart_fifo: zero-wait AHB-Lite UART with TX/RX FIFOs, programmable baud, parity,
// sticky error flags and a registered level interrupt
module ahb_uart_fifo #(
  parameter int          FIFO_DEPTH = 8,
  parameter int          DIV_W      = 16,
  parameter int unsigned DIV_RST    = 7
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel_i,
  input  logic        hwrite_i,
  input  logic        hready_i,
  input  logic [2:0]  hsize_i,
  input  logic [2:0]  hburst_i,
  input  logic [1:0]  htrans_i,
  input  logic [31:0] hwdata_i,
  input  logic [31:0] haddr_i,
  output logic        hreadyout_o,
  output logic        hresp_o,
  output logic [31:0] hrdata_o,
  output logic        tx,
  input  logic        rx,
  output logic        irq_o
);
  import ahb_uart_fifo_pkg::*;
  logic ap_valid, ap_write;
  logic [1:0] ap_addr;
  logic [5:0] ctrl;
  logic [DIV_W-1:0] baud, rx_half;
  logic rx_ovr, par_err, tx_ovf, irq_q;
  logic wr_data, wr_ctrl, wr_stat, wr_baud, rd_data;
  logic tx_full, tx_empty, rx_full, rx_empty, tx_pop, rx_push, rx_ovr_set, par_err_set;
  logic [7:0] tx_dout, rx_dout;
  uart_state_t tx_state, tx_state_n, rx_state, rx_state_n;
  logic [DIV_W-1:0] tx_cnt, tx_cnt_n, rx_cnt, rx_cnt_n;
  logic [7:0] tx_sh, tx_sh_n, rx_sh, rx_sh_n;
  logic [2:0] tx_bit, tx_bit_n, rx_bit, rx_bit_n;
  logic tx_par, tx_par_n, rx_pbit, rx_pbit_n, tx_tick, rx_tick;
  logic rx_s1, rx_s2, rx_s3;
  logic unused_ok;
  assign unused_ok = ^{hsize_i, hburst_i, htrans_i[0], haddr_i[31:4], haddr_i[1:0], hwdata_i[31:8]};
  assign hreadyout_o = 1'b1;
  assign hresp_o = 1'b0;
  assign irq_o = irq_q;
  assign wr_data = ap_valid & ap_write & (ap_addr == REG_DATA);
  assign wr_ctrl = ap_valid & ap_write & (ap_addr == REG_CTRL);
  assign wr_stat = ap_valid & ap_write & (ap_addr == REG_STAT);
  assign wr_baud = ap_valid & ap_write & (ap_addr == REG_BAUD);
  assign rd_data = ap_valid & ~ap_write & (ap_addr == REG_DATA);
  always_comb begin
    hrdata_o = '0;
    if (ap_valid && !ap_write)
      case (ap_addr)
        REG_DATA: hrdata_o[7:0] = rx_empty ? 8'h00 : rx_dout;
        REG_CTRL: hrdata_o[5:0] = ctrl;
        REG_STAT: hrdata_o[7:0] = {tx_ovf, par_err, rx_ovr, tx_state != S_IDLE, rx_empty, rx_full, tx_empty, tx_full};
        default:  hrdata_o[DIV_W-1:0] = baud;
      endcase
  end
  always_ff @(posedge hclk) begin
    if (hreset) begin
      ap_valid <= 1'b0;
      ap_write <= 1'b0;
      ap_addr <= '0;
      ctrl <= '0;
      baud <= DIV_W'(DIV_RST);
      rx_ovr <= 1'b0;
      par_err <= 1'b0;
      tx_ovf <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ap_valid <= hsel_i & hready_i & htrans_i[1];
      ap_write <= hwrite_i;
      ap_addr <= haddr_i[3:2];
      if (wr_ctrl) ctrl <= hwdata_i[5:0];
      if (wr_baud) baud <= hwdata_i[DIV_W-1:0];
      rx_ovr <= rx_ovr_set | (rx_ovr & ~(wr_stat & hwdata_i[STAT_RX_OVR]));
      par_err <= par_err_set | (par_err & ~(wr_stat & hwdata_i[STAT_PAR_ERR]));
      tx_ovf <= (wr_data & tx_full) | (tx_ovf & ~(wr_stat & hwdata_i[STAT_TX_OVF]));
      irq_q <= (ctrl[CTRL_RXNE_IE] & ~rx_empty) | (ctrl[CTRL_TXE_IE] & tx_empty) | rx_ovr | par_err;
    end
  end
  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(hclk), .rst(hreset), .push(wr_data), .pop(tx_pop), .din(hwdata_i[7:0]),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty)
  );
  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(hclk), .rst(hreset), .push(rx_push), .pop(rd_data), .din(rx_sh),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty)
  );
  // Bit timers reload from the live divisor only at bit boundaries
  assign tx_tick = tx_cnt == '0;
  assign rx_tick = rx_cnt == '0;
  assign rx_half = (baud == '0) ? '0 : (baud - 1'b1) >> 1;
  assign tx = (tx_state == S_START) ? 1'b0 : (tx_state == S_DATA) ? tx_sh[0] : (tx_state == S_PARITY) ? tx_par : 1'b1;
  always_comb begin
    tx_pop = ctrl[CTRL_TX_EN] & ~tx_empty & ((tx_state == S_IDLE) | ((tx_state == S_STOP) & tx_tick));
    tx_state_n = tx_state;
    tx_cnt_n = tx_tick ? baud : tx_cnt - 1'b1;
    tx_sh_n = tx_sh;
    tx_bit_n = tx_bit;
    tx_par_n = tx_par;
    if (tx_pop) begin
      tx_state_n = S_START;
      tx_cnt_n = baud;
      tx_sh_n = tx_dout;
      tx_par_n = parity(tx_dout, ctrl[CTRL_PAR_ODD]);
    end else if (tx_tick)
      case (tx_state)
        S_START: begin
          tx_state_n = S_DATA;
          tx_bit_n = '0;
        end
        S_DATA: begin
          tx_sh_n = tx_sh >> 1;
          tx_bit_n = tx_bit + 1'b1;
          if (&tx_bit) tx_state_n = ctrl[CTRL_PAR_EN] ? S_PARITY : S_STOP;
        end
        S_PARITY: tx_state_n = S_STOP;
        S_STOP:   tx_state_n = S_IDLE;
        default:  tx_state_n = S_IDLE;
      endcase
  end
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n = rx_tick ? baud : rx_cnt - 1'b1;
    rx_sh_n = rx_sh;
    rx_bit_n = rx_bit;
    rx_pbit_n = rx_pbit;
    rx_push = 1'b0;
    rx_ovr_set = 1'b0;
    par_err_set = 1'b0;
    case (rx_state)
      S_IDLE: if (ctrl[CTRL_RX_EN] & rx_s3 & ~rx_s2) begin
        rx_state_n = S_START;
        rx_cnt_n = rx_half;
      end
      S_START: if (rx_tick) begin
        rx_state_n = rx_s2 ? S_IDLE : S_DATA;
        rx_bit_n = '0;
      end
      S_DATA: if (rx_tick) begin
        rx_sh_n = {rx_s2, rx_sh[7:1]};
        rx_bit_n = rx_bit + 1'b1;
        if (&rx_bit) rx_state_n = ctrl[CTRL_PAR_EN] ? S_PARITY : S_STOP;
      end
      S_PARITY: if (rx_tick) begin
        rx_pbit_n = rx_s2;
        rx_state_n = S_STOP;
      end
      S_STOP: if (rx_tick) begin
        rx_state_n = S_IDLE;
        rx_push = rx_s2 & ~rx_full;
        rx_ovr_set = rx_s2 & rx_full;
        par_err_set = rx_s2 & ctrl[CTRL_PAR_EN] & (rx_pbit != parity(rx_sh, ctrl[CTRL_PAR_ODD]));
      end
      default: rx_state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge hclk) begin
    if (hreset) begin
      tx_state <= S_IDLE;
      tx_cnt <= '0;
      tx_sh <= '0;
      tx_bit <= '0;
      tx_par <= 1'b0;
      rx_state <= S_IDLE;
      rx_cnt <= '0;
      rx_sh <= '0;
      rx_bit <= '0;
      rx_pbit <= 1'b0;
      {rx_s1, rx_s2, rx_s3} <= 3'b111;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt <= tx_cnt_n;
      tx_sh <= tx_sh_n;
      tx_bit <= tx_bit_n;
      tx_par <= tx_par_n;
      rx_state <= rx_state_n;
      rx_cnt <= rx_cnt_n;
      rx_sh <= rx_sh_n;
      rx_bit <= rx_bit_n;
      rx_pbit <= rx_pbit_n;
      {rx_s1, rx_s2, rx_s3} <= {rx, rx_s1, rx_s2};
    end
  end
endmodule

// File: tb/tb_ahb_uart_fifo.sv
// tb_ahb_uart_fifo: randomized scenarios against a queue-based UART model
module tb_ahb_uart_fifo;
  logic hclk = 1'b0, hreset = 1'b1, hsel = 1'b0, hwrite = 1'b0, hready = 1'b1, rx = 1'b1;
  logic [2:0] hsize = 3'b010, hburst = 3'b000;
  logic [1:0] htrans = 2'b00;
  logic [31:0] hwdata = '0, haddr = '0, hrdata;
  logic hreadyout, hresp, tx, irq;
  int total = 0, bad = 0;
  int bit_cyc = 8;
  byte unsigned tx_q[$], rx_q[$];
  logic m_ovr = 1'b0, m_perr = 1'b0, m_ovf = 1'b0;
  always #5 hclk = ~hclk;
  ahb_uart_fifo dut (
    .hclk(hclk), .hreset(hreset), .hsel_i(hsel), .hwrite_i(hwrite), .hready_i(hready),
    .hsize_i(hsize), .hburst_i(hburst), .htrans_i(htrans), .hwdata_i(hwdata), .haddr_i(haddr),
    .hreadyout_o(hreadyout), .hresp_o(hresp), .hrdata_o(hrdata), .tx(tx), .rx(rx), .irq_o(irq)
  );
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge hclk); hsel = 1; hwrite = 1; htrans = 2'b10; haddr = {28'h0, a};
    @(negedge hclk); hsel = 0; hwrite = 0; htrans = 2'b00; hwdata = d;
    @(posedge hclk); #1;
  endtask
  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge hclk); hsel = 1; hwrite = 0; htrans = 2'b10; haddr = {28'h0, a};
    @(negedge hclk); hsel = 0; htrans = 2'b00; d = hrdata;
    @(posedge hclk); #1;
  endtask
  function automatic logic [10:0] frame(input logic [7:0] b, input logic pe, input logic odd);
    logic p;
    p = (($countones(b) % 2) == 1) ^ odd;
    return pe ? {1'b1, p, b, 1'b0} : {2'b11, b, 1'b0};
  endfunction
  function automatic logic [31:0] exp_stat();
    return {24'h0, m_ovf, m_perr, m_ovr, 1'b0, rx_q.size() == 0, rx_q.size() == 8, tx_q.size() == 0, tx_q.size() == 8};
  endfunction
  task automatic capture(input int nbits, output logic [10:0] f, output int gap);
    f = '1; gap = 0;
    while (tx !== 1'b0 && gap < 400) begin @(posedge hclk); #1; gap++; end
    if (tx !== 1'b0) begin
      total++; bad++;
      $display("FAIL tx_start_timeout: tx=%b required=0", tx);
    end else begin
      repeat (bit_cyc / 2) @(posedge hclk);
      #1 f[0] = tx;
      for (int i = 1; i < nbits; i++) begin
        repeat (bit_cyc) @(posedge hclk);
        #1 f[i] = tx;
      end
    end
  endtask
  task automatic rx_frame(input logic [7:0] b, input logic pe, input logic odd, input logic bad_par, input logic stop);
    logic pbit;
    pbit = (($countones(b) % 2) == 1) ^ odd ^ bad_par;
    @(negedge hclk); rx = 0;
    repeat (bit_cyc) @(negedge hclk);
    for (int i = 0; i < 8; i++) begin rx = b[i]; repeat (bit_cyc) @(negedge hclk); end
    if (pe) begin rx = pbit; repeat (bit_cyc) @(negedge hclk); end
    rx = stop; repeat (bit_cyc) @(negedge hclk);
    rx = 1; repeat (bit_cyc) @(negedge hclk);
    if (stop) begin
      if (rx_q.size() < 8) rx_q.push_back(b); else m_ovr = 1;
      if (pe && bad_par) m_perr = 1;
    end
  endtask
  task automatic test_reset();
    logic [31:0] r;
    hreset = 1; repeat (3) @(posedge hclk); #1 hreset = 0;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", tx); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    total++; if (hrdata !== 32'h0) begin bad++; $display("FAIL reset_hrdata: got %h want 0", hrdata); end
    rd(4'h8, r); total++; if (r !== 32'h0000_000A) begin bad++; $display("FAIL reset_stat: got %h want 0000000a", r); end
    rd(4'hC, r); total++; if (r !== 32'd7) begin bad++; $display("FAIL reset_baud: got %h want 7", r); end
    rd(4'h4, r); total++; if (r !== 32'h0) begin bad++; $display("FAIL reset_ctrl: got %h want 0", r); end
    rd(4'h0, r); total++; if (r !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", r); end
  endtask
  task automatic test_tx();
    logic [31:0] r;
    logic [10:0] f;
    logic [7:0] b;
    int gap;
    wr(4'h4, 32'h01);
    for (int k = 0; k < 3; k++) begin
      b = (k == 0) ? 8'h27 : 8'($urandom);
      wr(4'h0, {24'h0, b});
      fork
        capture(10, f, gap);
        begin
          repeat (20) @(posedge hclk);
          rd(4'h8, r);
          total++; if (r[4] !== 1'b1) begin bad++; $display("FAIL tx_busy: got %b want 1", r[4]); end
        end
      join
      total++; if (f !== frame(b, 0, 0)) begin bad++; $display("FAIL tx_frame: got %b want %b", f, frame(b, 0, 0)); end
    end
    repeat (10) @(posedge hclk);
    rd(4'h8, r); total++; if (r !== exp_stat()) begin bad++; $display("FAIL tx_idle_stat: got %h want %h", r, exp_stat()); end
  endtask
  task automatic test_back_to_back();
    logic [7:0] bs [3];
    logic [10:0] f;
    int gap;
    for (int i = 0; i < 3; i++) bs[i] = 8'($urandom);
    fork
      for (int i = 0; i < 3; i++) wr(4'h0, {24'h0, bs[i]});
      for (int i = 0; i < 3; i++) begin
        capture(10, f, gap);
        total++; if (f !== frame(bs[i], 0, 0)) begin bad++; $display("FAIL b2b_frame%0d: got %b want %b", i, f, frame(bs[i], 0, 0)); end
        if (i > 0) begin
          total++; if (gap !== bit_cyc / 2) begin bad++; $display("FAIL b2b_gap%0d: got %0d want %0d", i, gap, bit_cyc / 2); end
        end
      end
    join
  endtask
  task automatic test_parity();
    logic [10:0] f;
    logic [7:0] b;
    int gap;
    for (int k = 0; k < 4; k++) begin
      logic odd;
      odd = (k >= 2);
      wr(4'h4, odd ? 32'h0F : 32'h07);
      b = (k == 0) ? 8'h03 : 8'($urandom);
      wr(4'h0, {24'h0, b});
      capture(11, f, gap);
      total++; if (f !== frame(b, 1, odd)) begin bad++; $display("FAIL parity_frame%0d: got %b want %b", k, f, frame(b, 1, odd)); end
      repeat (6) @(posedge hclk);
    end
    wr(4'h4, 32'h00);
  endtask
  task automatic test_rx();
    logic [31:0] r;
    wr(4'h4, 32'h02);
    rx_frame(8'h55, 0, 0, 0, 1);
    rx_frame(8'hAA, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) rx_frame(8'($urandom), 0, 0, 0, 1);
    rd(4'h8, r); total++; if (r !== exp_stat()) begin bad++; $display("FAIL rx_stat: got %h want %h", r, exp_stat()); end
    while (rx_q.size() > 0) begin
      rd(4'h0, r);
      total++; if (r !== {24'h0, rx_q[0]}) begin bad++; $display("FAIL rx_data: got %h want %h", r, rx_q[0]); end
      void'(rx_q.pop_front());
    end
    rd(4'h0, r); total++; if (r !== 32'h0) begin bad++; $display("FAIL rx_empty_read: got %h want 0", r); end
  endtask
  task automatic test_rx_parity();
    logic [31:0] r;
    wr(4'h4, 32'h06);
    rx_frame(8'h01, 1, 0, 1, 1);
    rd(4'h8, r); total++; if (r !== exp_stat()) begin bad++; $display("FAIL par_err_stat: got %h want %h", r, exp_stat()); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL par_err_irq: got %b want 1", irq); end
    rd(4'h0, r); total++; if (r !== {24'h0, rx_q[0]}) begin bad++; $display("FAIL par_err_data: got %h want %h", r, rx_q[0]); end
    void'(rx_q.pop_front());
    wr(4'h8, 32'h40); m_perr = 0;
    @(posedge hclk); #1;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL par_clr_irq: got %b want 0", irq); end
    wr(4'h4, 32'h0E);
    rx_frame(8'($urandom), 1, 1, 0, 1);
    rd(4'h8, r); total++; if (r !== exp_stat()) begin bad++; $display("FAIL odd_ok_stat: got %h want %h", r, exp_stat()); end
    rd(4'h0, r); total++; if (r !== {24'h0, rx_q[0]}) begin bad++; $display("FAIL odd_ok_data: got %h want %h", r, rx_q[0]); end
    void'(rx_q.pop_front());
  endtask
  task automatic test_false_start();
    logic [31:0] r;
    wr(4'h4, 32'h02);
    @(negedge hclk); rx = 0; repeat (2) @(negedge hclk); rx = 1;
    repeat (40) @(negedge hclk);
    rd(4'h8, r); total++; if (r !== exp_stat()) begin bad++; $display("FAIL false_start_stat: got %h want %h", r, exp_stat()); end
    rx_frame(8'($urandom), 0, 0, 0, 0);
    rd(4'h8, r); total++; if (r !== exp_stat()) begin bad++; $display("FAIL framing_stat: got %h want %h", r, exp_stat()); end
    rx_frame(8'($urandom), 0, 0, 0, 1);
    rd(4'h0, r); total++; if (r !== {24'h0, rx_q[0]}) begin bad++; $display("FAIL recover_data: got %h want %h", r, rx_q[0]); end
    void'(rx_q.pop_front());
  endtask
  task automatic test_tx_ovf();
    logic [31:0] r;
    logic [10:0] f;
    logic [7:0] b;
    int gap;
    wr(4'h4, 32'h00);
    for (int k = 0; k < 9; k++) begin
      b = 8'($urandom);
      wr(4'h0, {24'h0, b});
      if (tx_q.size() < 8) tx_q.push_back(b); else m_ovf = 1;
    end
    rd(4'h8, r); total++; if (r !== exp_stat()) begin bad++; $display("FAIL tx_ovf_stat: got %h want %h", r, exp_stat()); end
    wr(4'h8, 32'h80); m_ovf = 0;
    rd(4'h8, r); total++; if (r !== exp_stat()) begin bad++; $display("FAIL tx_ovf_clr: got %h want %h", r, exp_stat()); end
    wr(4'h4, 32'h21);
    @(posedge hclk); #1;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL txe_irq_busy: got %b want 0", irq); end
    while (tx_q.size() > 0) begin
      capture(10, f, gap);
      total++; if (f !== frame(tx_q[0], 0, 0)) begin bad++; $display("FAIL ovf_frame: got %b want %b", f, frame(tx_q[0], 0, 0)); end
      void'(tx_q.pop_front());
    end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL txe_irq: got %b want 1", irq); end
    repeat (8) @(posedge hclk);
    wr(4'h4, 32'h00);
    @(posedge hclk); #1;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL txe_irq_off: got %b want 0", irq); end
  endtask
  task automatic test_rx_ovr();
    logic [31:0] r;
    wr(4'h4, 32'h12);
    for (int k = 0; k < 9; k++) rx_frame(8'($urandom), 0, 0, 0, 1);
    rd(4'h8, r); total++; if (r !== exp_stat()) begin bad++; $display("FAIL rx_ovr_stat: got %h want %h", r, exp_stat()); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL rx_ovr_irq: got %b want 1", irq); end
    while (rx_q.size() > 0) begin
      rd(4'h0, r);
      total++; if (r !== {24'h0, rx_q[0]}) begin bad++; $display("FAIL ovr_data: got %h want %h", r, rx_q[0]); end
      void'(rx_q.pop_front());
    end
    rd(4'h0, r); total++; if (r !== 32'h0) begin bad++; $display("FAIL ovr_empty_read: got %h want 0", r); end
    wr(4'h8, 32'h20); m_ovr = 0;
    rd(4'h8, r); total++; if (r !== exp_stat()) begin bad++; $display("FAIL rx_ovr_clr: got %h want %h", r, exp_stat()); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rx_ovr_irq_clr: got %b want 0", irq); end
  endtask
  task automatic test_baud();
    logic [31:0] r;
    logic [10:0] f;
    logic [7:0] b;
    int gap;
    wr(4'hC, 32'd3); bit_cyc = 4;
    rd(4'hC, r); total++; if (r !== 32'd3) begin bad++; $display("FAIL baud_rd: got %h want 3", r); end
    wr(4'h4, 32'h03);
    b = 8'($urandom);
    wr(4'h0, {24'h0, b});
    capture(10, f, gap);
    total++; if (f !== frame(b, 0, 0)) begin bad++; $display("FAIL baud_tx: got %b want %b", f, frame(b, 0, 0)); end
    repeat (4) @(posedge hclk);
    rx_frame(8'($urandom), 0, 0, 0, 1);
    rd(4'h0, r); total++; if (r !== {24'h0, rx_q[0]}) begin bad++; $display("FAIL baud_rx: got %h want %h", r, rx_q[0]); end
    void'(rx_q.pop_front());
    wr(4'hC, 32'd7); bit_cyc = 8;
  endtask
  task automatic test_reset_midframe();
    logic [31:0] r;
    int lows;
    wr(4'h4, 32'h01);
    wr(4'h0, {24'h0, 8'($urandom)});
    wr(4'h0, {24'h0, 8'($urandom)});
    repeat (25) @(posedge hclk);
    rd(4'h8, r); total++; if (r[4] !== 1'b1) begin bad++; $display("FAIL midframe_busy: got %b want 1", r[4]); end
    @(negedge hclk); hreset = 1;
    @(posedge hclk); #1;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL midframe_tx: got %b want 1", tx); end
    hreset = 0;
    tx_q.delete(); rx_q.delete(); m_ovr = 0; m_perr = 0; m_ovf = 0;
    rd(4'h8, r); total++; if (r !== exp_stat()) begin bad++; $display("FAIL midframe_stat: got %h want %h", r, exp_stat()); end
    rd(4'h4, r); total++; if (r !== 32'h0) begin bad++; $display("FAIL midframe_ctrl: got %h want 0", r); end
    lows = 0;
    for (int i = 0; i < 100; i++) begin @(posedge hclk); #1; if (tx !== 1'b1) lows++; end
    total++; if (lows !== 0) begin bad++; $display("FAIL midframe_quiet: got %0d low cycles want 0", lows); end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_tx();
    test_back_to_back();
    test_parity();
    test_rx();
    test_rx_parity();
    test_false_start();
    test_tx_ovf();
    test_rx_ovr();
    test_baud();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
